// File: rtl/id_operand_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : id_operand_stage
// Description : MIPS decode/operand stage. Contains the IF->ID register, an
//               instruction hold buffer, a priority bypass network, the
//               load-use interlock and branch/jump resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
    parameter int DATA_W          = 32,
    parameter int NUM_FWD         = 3,
    parameter int LOAD_USE_STAGES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_id,
    input  logic                      bubble_id,
    input  logic                      if_valid,
    input  logic [31:0]               if_pc,
    input  logic [31:0]               inst_rdata,
    output logic [4:0]                rf_raddr1,
    output logic [4:0]                rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [5*NUM_FWD-1:0]      fwd_waddr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic                      id_valid,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_inst,
    output logic [DATA_W-1:0]         rs_val,
    output logic [DATA_W-1:0]         rt_val,
    output logic                      stallreq,
    output logic                      br_taken,
    output logic [31:0]               br_target
);

    localparam logic [5:0] c_op_special = 6'b000000;
    localparam logic [5:0] c_op_regimm  = 6'b000001;
    localparam logic [5:0] c_op_j       = 6'b000010;
    localparam logic [5:0] c_op_jal     = 6'b000011;
    localparam logic [5:0] c_op_beq     = 6'b000100;
    localparam logic [5:0] c_op_bne     = 6'b000101;
    localparam logic [5:0] c_op_blez    = 6'b000110;
    localparam logic [5:0] c_op_bgtz    = 6'b000111;
    localparam logic [5:0] c_op_lui     = 6'b001111;
    localparam logic [5:0] c_fn_sll     = 6'b000000;
    localparam logic [5:0] c_fn_srl     = 6'b000010;
    localparam logic [5:0] c_fn_sra     = 6'b000011;
    localparam logic [5:0] c_fn_jr      = 6'b001000;
    localparam logic [5:0] c_fn_jalr    = 6'b001001;

    logic              r_valid;
    logic [31:0]       r_pc;
    logic              r_hold_v;
    logic [31:0]       r_hold_inst;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rt_field;
    logic              w_rs_used;
    logic              w_rt_used;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_rs_load;
    logic              w_rt_load;
    logic              w_stall;
    logic [31:0]       w_pc4;
    logic [31:0]       w_br_tgt;
    logic [31:0]       w_j_tgt;
    logic              w_rs_neg;
    logic              w_rs_zero;
    logic              w_cond;
    logic [31:0]       w_tgt;

    // The hold buffer only captures on the first stalled cycle of a valid entry,
    // because the SRAM word is lost once IF moves on.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_hold_v    <= 1'b0;
            r_hold_inst <= 32'd0;
        end else if (stall_id) begin
            if (!r_hold_v && r_valid) begin
                r_hold_v    <= 1'b1;
                r_hold_inst <= inst_rdata;
            end
        end else if (bubble_id) begin
            r_valid  <= 1'b0;
            r_pc     <= 32'd0;
            r_hold_v <= 1'b0;
        end else begin
            r_valid  <= if_valid;
            r_pc     <= if_pc;
            r_hold_v <= 1'b0;
        end
    end

    assign id_valid  = r_valid;
    assign id_pc     = r_pc;
    assign id_inst   = !r_valid ? 32'd0 : (r_hold_v ? r_hold_inst : inst_rdata);
    assign rf_raddr1 = id_inst[25:21];
    assign rf_raddr2 = id_inst[20:16];

    assign w_op       = id_inst[31:26];
    assign w_funct    = id_inst[5:0];
    assign w_rt_field = id_inst[20:16];

    // Scan oldest to youngest so the lowest matching index ends up selected.
    function automatic void bypass(input  logic [4:0]        addr,
                                   input  logic [DATA_W-1:0] rf_val,
                                   output logic [DATA_W-1:0] val,
                                   output logic              load_hit);
        val      = rf_val;
        load_hit = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == addr)) begin
                val      = fwd_wdata[DATA_W*i +: DATA_W];
                load_hit = fwd_is_load[i] && (i < LOAD_USE_STAGES);
            end
        end
        if (addr == 5'd0) begin
            val      = '0;
            load_hit = 1'b0;
        end
    endfunction

    always_comb begin
        bypass(rf_raddr1, rf_rdata1, w_rs_val, w_rs_load);
    end

    always_comb begin
        bypass(rf_raddr2, rf_rdata2, w_rt_val, w_rt_load);
    end

    assign rs_val = w_rs_val;
    assign rt_val = w_rt_val;

    assign w_rs_used = !((w_op == c_op_j) || (w_op == c_op_jal) || (w_op == c_op_lui) ||
                         ((w_op == c_op_special) &&
                          ((w_funct == c_fn_sll) || (w_funct == c_fn_srl) || (w_funct == c_fn_sra))));
    assign w_rt_used = (w_op == c_op_special) || (w_op == c_op_beq) || (w_op == c_op_bne) ||
                       (w_op[5:3] == 3'b101);

    assign w_stall  = r_valid && ((w_rs_used && w_rs_load) || (w_rt_used && w_rt_load));
    assign stallreq = w_stall;

    assign w_pc4     = r_pc + 32'd4;
    assign w_br_tgt  = w_pc4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
    assign w_j_tgt   = {w_pc4[31:28], id_inst[25:0], 2'b00};
    assign w_rs_neg  = w_rs_val[DATA_W-1];
    assign w_rs_zero = (w_rs_val == '0);

    always_comb begin
        w_cond = 1'b0;
        w_tgt  = w_br_tgt;
        case (w_op)
            c_op_special: begin
                if ((w_funct == c_fn_jr) || (w_funct == c_fn_jalr)) begin
                    w_cond = 1'b1;
                    w_tgt  = w_rs_val[31:0];
                end
            end
            c_op_regimm: begin
                if (w_rt_field == 5'b00001) begin
                    w_cond = !w_rs_neg;
                end else if (w_rt_field == 5'b00000) begin
                    w_cond = w_rs_neg;
                end
            end
            c_op_j, c_op_jal: begin
                w_cond = 1'b1;
                w_tgt  = w_j_tgt;
            end
            c_op_beq:  w_cond = (w_rs_val == w_rt_val);
            c_op_bne:  w_cond = (w_rs_val != w_rt_val);
            c_op_blez: w_cond = w_rs_neg || w_rs_zero;
            c_op_bgtz: w_cond = !w_rs_neg && !w_rs_zero;
            default:   w_cond = 1'b0;
        endcase
    end

    assign br_taken  = w_cond && r_valid && !w_stall;
    assign br_target = br_taken ? w_tgt : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_id_operand_stage
// Description : Directed-vector scoreboard bench for id_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam logic [8:0] ALL = 9'h1FF;

    logic           clk = 1'b0;
    logic           rst, flush, stall_id, bubble_id, if_valid;
    logic [31:0]    if_pc, inst_rdata;
    logic [4:0]     rf_raddr1, rf_raddr2;
    logic [DW-1:0]  rf_rdata1, rf_rdata2;
    logic [NF-1:0]  fwd_we, fwd_is_load;
    logic [5*NF-1:0] fwd_waddr;
    logic [DW*NF-1:0] fwd_wdata;
    logic           id_valid, stallreq, br_taken;
    logic [31:0]    id_pc, id_inst, br_target;
    logic [DW-1:0]  rs_val, rt_val;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [8:0]  mask;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_operand_stage #(.DATA_W(DW), .NUM_FWD(NF), .LOAD_USE_STAGES(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .bubble_id(bubble_id),
        .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rs_val(rs_val), .rt_val(rt_val), .stallreq(stallreq),
        .br_taken(br_taken), .br_target(br_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_is_load = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d, input logic ld);
        fwd_we[i]          = 1'b1;
        fwd_waddr[5*i +: 5] = a;
        fwd_wdata[DW*i +: DW] = d;
        fwd_is_load[i]     = ld;
    endtask

    task automatic expect_out(input string name, input logic [8:0] mask, input logic v,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic st, input logic bt, input logic [31:0] tgt);
        exp_t e;
        e.cyc = cyc; e.name = name; e.mask = mask; e.valid = v; e.pc = pc; e.inst = inst;
        e.rs = rs; e.rt = rt; e.stall = st; e.bt = bt; e.tgt = tgt;
        q.push_back(e);
    endtask

    task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, fld, act, exp);
        end
    endtask

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s.stale: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
            end else begin
                if (e.mask[0]) cmp(e.name, "id_valid",  {31'd0, id_valid}, {31'd0, e.valid});
                if (e.mask[1]) cmp(e.name, "id_pc",     id_pc, e.pc);
                if (e.mask[2]) cmp(e.name, "id_inst",   id_inst, e.inst);
                if (e.mask[3]) cmp(e.name, "rs_val",    rs_val, e.rs);
                if (e.mask[4]) cmp(e.name, "rt_val",    rt_val, e.rt);
                if (e.mask[5]) cmp(e.name, "stallreq",  {31'd0, stallreq}, {31'd0, e.stall});
                if (e.mask[6]) cmp(e.name, "br_taken",  {31'd0, br_taken}, {31'd0, e.bt});
                if (e.mask[7]) cmp(e.name, "br_target", br_target, e.tgt);
                if (e.mask[8]) cmp(e.name, "rf_raddr",  {22'd0, rf_raddr1, rf_raddr2},
                                   {22'd0, e.inst[25:21], e.inst[20:16]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall_id = 1'b0; bubble_id = 1'b0;
        if_valid = 1'b1; if_pc = 32'h40; inst_rdata = 32'h3C011234;
        rf_rdata1 = '0; rf_rdata2 = '0;
        clr_fwd();
        tick(); tick();
        expect_out("reset", ALL, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; if_pc = 32'h100;
        tick();

        inst_rdata = 32'h00221821; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        set_src(0, 5'd1, 32'hA, 1'b0); set_src(1, 5'd2, 32'h5, 1'b0); set_src(2, 5'd1, 32'hB, 1'b0);
        expect_out("bypass_prio", ALL, 1, 32'h100, 32'h00221821, 32'hA, 32'h5, 0, 0, 0);
        if_pc = 32'h104; tick();

        inst_rdata = 32'h00021821; rf_rdata1 = 32'h77; set_src(0, 5'd0, 32'hFF, 1'b0);
        expect_out("zero_reg", ALL, 1, 32'h104, 32'h00021821, 32'h0, 32'h5, 0, 0, 0);
        if_pc = 32'h108; tick();

        inst_rdata = 32'h00C71821; clr_fwd(); rf_rdata1 = 32'h11112222; rf_rdata2 = 32'h33334444;
        expect_out("rf_fallback", ALL, 1, 32'h108, 32'h00C71821, 32'h11112222, 32'h33334444, 0, 0, 0);
        if_pc = 32'h10C; tick();

        inst_rdata = 32'h00802821; set_src(0, 5'd4, 32'hDEAD, 1'b1); stall_id = 1'b1;
        expect_out("load_use_ex", 9'h1F7, 1, 32'h10C, 32'h00802821, 0, 32'h0, 1, 0, 0);
        if_pc = 32'h200; tick();

        clr_fwd(); set_src(1, 5'd4, 32'h12345678, 1'b1); stall_id = 1'b0; inst_rdata = 32'hFFFFFFFF;
        expect_out("load_use_mem", ALL, 1, 32'h10C, 32'h00802821, 32'h12345678, 32'h0, 0, 0, 0);
        tick();

        clr_fwd(); inst_rdata = 32'h3C011234; stall_id = 1'b1; rf_rdata1 = '0; rf_rdata2 = '0;
        expect_out("hold_c1", ALL, 1, 32'h200, 32'h3C011234, 0, 0, 0, 0, 0);
        tick();
        inst_rdata = 32'hDEADBEEF;
        expect_out("hold_c2", ALL, 1, 32'h200, 32'h3C011234, 0, 0, 0, 0, 0);
        tick();
        inst_rdata = 32'h01234567;
        expect_out("hold_c3", ALL, 1, 32'h200, 32'h3C011234, 0, 0, 0, 0, 0);
        tick();
        stall_id = 1'b0; if_pc = 32'h204;
        expect_out("hold_release", ALL, 1, 32'h200, 32'h3C011234, 0, 0, 0, 0, 0);
        tick();
        inst_rdata = 32'h24420001;
        expect_out("hold_cleared", ALL, 1, 32'h204, 32'h24420001, 0, 0, 0, 0, 0);
        if_pc = 32'h1000; tick();

        inst_rdata = 32'h1021FFFF; rf_rdata1 = 32'h55; rf_rdata2 = 32'h55;
        expect_out("beq_taken", ALL, 1, 32'h1000, 32'h1021FFFF, 32'h55, 32'h55, 0, 1, 32'h1000);
        if_pc = 32'h1004; tick();
        inst_rdata = 32'h1022FFFF; rf_rdata2 = 32'h56;
        expect_out("beq_ne", ALL, 1, 32'h1004, 32'h1022FFFF, 32'h55, 32'h56, 0, 0, 0);
        if_pc = 32'h1008; tick();
        inst_rdata = 32'h1C000004;
        expect_out("bgtz_zero", ALL, 1, 32'h1008, 32'h1C000004, 0, 0, 0, 0, 0);
        if_pc = 32'h100C; tick();
        inst_rdata = 32'h1C200004;
        expect_out("bgtz_pos", ALL, 1, 32'h100C, 32'h1C200004, 32'h55, 0, 0, 1, 32'h1020);
        if_pc = 32'h1010; tick();
        inst_rdata = 32'h04200002; rf_rdata1 = 32'h80000000;
        expect_out("bltz_neg", ALL, 1, 32'h1010, 32'h04200002, 32'h80000000, 0, 0, 1, 32'h101C);
        if_pc = 32'h1014; tick();
        inst_rdata = 32'h04210002;
        expect_out("bgez_neg", ALL, 1, 32'h1014, 32'h04210002, 32'h80000000, 32'h56, 0, 0, 0);
        if_pc = 32'hBFC00010; tick();
        inst_rdata = 32'h0C000040;
        expect_out("jal", ALL, 1, 32'hBFC00010, 32'h0C000040, 0, 0, 0, 1, 32'hB0000100);
        if_pc = 32'hBFC00014; tick();
        inst_rdata = 32'h03E00008; rf_rdata1 = 32'h80000004;
        expect_out("jr", ALL, 1, 32'hBFC00014, 32'h03E00008, 32'h80000004, 0, 0, 1, 32'h80000004);
        if_pc = 32'hBFC00018; tick();
        inst_rdata = 32'h1084FFFF; set_src(0, 5'd4, 32'h0, 1'b1);
        expect_out("beq_load_use", 9'h1E7, 1, 32'hBFC00018, 32'h1084FFFF, 0, 0, 1, 0, 0);
        if_pc = 32'h300; tick();

        clr_fwd(); inst_rdata = 32'h00221821; rf_rdata1 = '0; rf_rdata2 = '0;
        stall_id = 1'b1; flush = 1'b1;
        expect_out("pre_flush", ALL, 1, 32'h300, 32'h00221821, 0, 0, 0, 0, 0);
        if_pc = 32'h304; tick();
        flush = 1'b0; stall_id = 1'b0;
        expect_out("flush_stall", ALL, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        inst_rdata = 32'h08000040; bubble_id = 1'b1;
        expect_out("jump", ALL, 1, 32'h304, 32'h08000040, 0, 0, 0, 1, 32'h100);
        tick();
        bubble_id = 1'b0; if_valid = 1'b0;
        expect_out("bubble", ALL, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
